// File: rtl/simple_processor_pkg.sv
// Shared decode definitions for the simple processor: widths, operation encoding
// and the per-opcode operand-usage helpers.
package simple_processor_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_REGS    = 8;
  localparam int REG_AW      = $clog2(NUM_REGS);
  localparam int INSTR_WIDTH = 16;

  typedef enum logic [3:0] {
    FUNC_AND  = 4'd0,
    FUNC_OR   = 4'd1,
    FUNC_XOR  = 4'd2,
    FUNC_NOT  = 4'd3,
    FUNC_ADD  = 4'd4,
    FUNC_SUB  = 4'd5,
    FUNC_ADDI = 4'd6,
    FUNC_SLL  = 4'd7,
    FUNC_SLLI = 4'd8,
    FUNC_SLR  = 4'd9,
    FUNC_SLRI = 4'd10
  } func_t;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return (op == FUNC_AND) || (op == FUNC_OR) || (op == FUNC_XOR) || (op == FUNC_ADD) ||
           (op == FUNC_SUB) || (op == FUNC_SLL) || (op == FUNC_SLR);
  endfunction

  function automatic logic is_imm(input logic [3:0] op);
    return (op == FUNC_ADDI) || (op == FUNC_SLLI) || (op == FUNC_SLRI);
  endfunction

endpackage

// File: rtl/decode_issue_reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, cleared by the asynchronous reset.
module reg_file
  import simple_processor_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  we_i,
  input  logic [REG_AW-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [REG_AW-1:0]     raddr1_i,
  input  logic [REG_AW-1:0]     raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (we_i) begin
      r_regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = r_regs[raddr1_i];
  assign rdata2_o = r_regs[raddr2_i];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: scoreboarded operand fetch into a one-entry issue slot.
// Define DECODE_ISSUE_FORWARD_EN to forward a same-cycle write-back into issue.
module decode_issue
  import simple_processor_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output func_t                 func_o,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic [5:0]            imm_o,
  output logic [REG_AW-1:0]     rd_addr_o,
  input  logic                  wb_en_i,
  input  logic [REG_AW-1:0]     wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  illegal_o,
  output logic [31:0]           issue_count_o
);

  logic [3:0]            w_op;
  logic [REG_AW-1:0]     w_rd, w_rs1, w_rs2;
  logic [5:0]            w_imm;
  logic                  w_legal, w_uses_rs2, w_imm_en;
  logic [DATA_WIDTH-1:0] w_rf_rs1, w_rf_rs2, w_rs1_data, w_rs2_data;
  logic [NUM_REGS-1:0]   w_wb_clr, w_set, w_pend_eff;
  logic                  w_hazard, w_accept, w_issue;

  logic [NUM_REGS-1:0]   r_pend;
  logic                  r_valid;
  func_t                 r_func;
  logic [DATA_WIDTH-1:0] r_rs1, r_rs2;
  logic [5:0]            r_imm;
  logic [REG_AW-1:0]     r_rd;
  logic                  r_illegal;
  logic [31:0]           r_count;

  assign w_op  = instr_i[15:12];
  assign w_rd  = instr_i[11:9];
  assign w_rs1 = instr_i[8:6];
  assign w_rs2 = instr_i[5:3];
  assign w_imm = instr_i[5:0];

  assign w_legal    = is_legal(w_op);
  assign w_uses_rs2 = uses_rs2(w_op);
  assign w_imm_en   = is_imm(w_op);

  reg_file u_reg_file (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .we_i     (wb_en_i),
    .waddr_i  (wb_addr_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (w_rs1),
    .raddr2_i (w_rs2),
    .rdata1_o (w_rf_rs1),
    .rdata2_o (w_rf_rs2)
  );

  assign w_wb_clr = wb_en_i ? (NUM_REGS'(1) << wb_addr_i) : '0;

`ifdef DECODE_ISSUE_FORWARD_EN
  assign w_pend_eff = r_pend & ~w_wb_clr;
  assign w_rs1_data = (wb_en_i && (wb_addr_i == w_rs1)) ? wb_data_i : w_rf_rs1;
  assign w_rs2_data = (wb_en_i && (wb_addr_i == w_rs2)) ? wb_data_i : w_rf_rs2;
`else
  assign w_pend_eff = r_pend;
  assign w_rs1_data = w_rf_rs1;
  assign w_rs2_data = w_rf_rs2;
`endif

  // Illegal opcodes never wait on the scoreboard; they are simply consumed.
  assign w_hazard = w_legal & (w_pend_eff[w_rs1] | (w_uses_rs2 & w_pend_eff[w_rs2]) |
                               w_pend_eff[w_rd]);
  assign instr_ready_o = (!r_valid | ex_ready_i) & !w_hazard;
  assign w_accept      = instr_valid_i & instr_ready_o;
  assign w_issue       = w_accept & w_legal;
  assign w_set         = w_issue ? (NUM_REGS'(1) << w_rd) : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_valid   <= 1'b0;
      r_func    <= FUNC_AND;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
      r_pend    <= '0;
    end else begin
      if (w_issue) begin
        r_valid <= 1'b1;
        r_func  <= func_t'(w_op);
        r_rs1   <= w_rs1_data;
        r_rs2   <= w_uses_rs2 ? w_rs2_data : '0;
        r_imm   <= w_imm_en ? w_imm : '0;
        r_rd    <= w_rd;
        r_count <= r_count + 32'd1;
      end else if (ex_ready_i) begin
        r_valid <= 1'b0;
      end
      r_illegal <= w_accept & !w_legal;
      // A new claim on a register outranks a write-back releasing it.
      r_pend    <= (r_pend & ~w_wb_clr) | w_set;
    end
  end

  assign ex_valid_o    = r_valid;
  assign func_o        = r_func;
  assign rs1_data_o    = r_rs1;
  assign rs2_data_o    = r_rs2;
  assign imm_o         = r_imm;
  assign rd_addr_o     = r_rd;
  assign illegal_o     = r_illegal;
  assign issue_count_o = r_count;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a vector table for the decode paths plus
// hand-written stall, back-pressure, illegal-opcode and reset sequences.
module tb_decode_issue;
  import simple_processor_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [15:0] instr_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  func_t       func_o;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic [5:0]  imm_o;
  logic [2:0]  rd_addr_o;
  logic        wb_en_i;
  logic [2:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        illegal_o;
  logic [31:0] issue_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  decode_issue dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .func_o        (func_o),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .imm_o         (imm_o),
    .rd_addr_o     (rd_addr_o),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .illegal_o     (illegal_o),
    .issue_count_o (issue_count_o)
  );

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  func;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  imm;
    logic [2:0]  rd;
    logic [31:0] wbval;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
    wb_en_i   = 1'b1;
    wb_addr_i = addr;
    wb_data_i = data;
    tick();
    wb_en_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0650, 4'd0,  32'hA5A5A5A5, 32'h5A5A5A5A, 6'h00, 3'd3, 32'h11111111};
    vecs[1] = '{16'h6843, 4'd6,  32'hA5A5A5A5, 32'h00000000, 6'h03, 3'd4, 32'h22222222};
    vecs[2] = '{16'hAAC2, 4'd10, 32'h11111111, 32'h00000000, 6'h02, 3'd5, 32'h33333333};
    vecs[3] = '{16'h3D38, 4'd3,  32'h22222222, 32'h00000000, 6'h00, 3'd6, 32'h44444444};
    vecs[4] = '{16'h5F70, 4'd5,  32'h33333333, 32'h44444444, 6'h00, 3'd7, 32'h55555555};
    vecs[5] = '{16'h71C8, 4'd7,  32'h55555555, 32'hA5A5A5A5, 6'h00, 3'd0, 32'h66666666};
    vecs[6] = '{16'h1210, 4'd1,  32'h66666666, 32'h5A5A5A5A, 6'h00, 3'd1, 32'h77777777};
    vecs[7] = '{16'h2448, 4'd2,  32'h77777777, 32'h77777777, 6'h00, 3'd2, 32'h88888888};
    vecs[8] = '{16'h86BF, 4'd8,  32'h88888888, 32'h00000000, 6'h3F, 3'd3, 32'h99999999};
    vecs[9] = '{16'h48C0, 4'd4,  32'h99999999, 32'h66666666, 6'h00, 3'd4, 32'hAAAAAAAA};

    arst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; ex_ready_i = 1'b1;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    #22;
    arst_i = 1'b0;
    chk("reset ex_valid", 32'(ex_valid_o), 32'd0);
    chk("reset count", issue_count_o, 32'd0);
    chk("reset illegal", 32'(illegal_o), 32'd0);
    chk("reset rs1", rs1_data_o, 32'd0);
    chk("reset ready", 32'(instr_ready_o), 32'd1);
    $display("reset: ex_valid=%0d count=%0d", ex_valid_o, issue_count_o);
    tick();

    wb_write(3'd1, 32'hA5A5A5A5);
    wb_write(3'd2, 32'h5A5A5A5A);

    // Table: issue, check the slot one cycle later, then write back rd.
    for (int i = 0; i < 10; i++) begin
      instr_valid_i = 1'b1;
      instr_i = vecs[i].instr;
      #1;
      chk("vec ready", 32'(instr_ready_o), 32'd1);
      tick();
      instr_valid_i = 1'b0;
      chk("vec ex_valid", 32'(ex_valid_o), 32'd1);
      chk("vec func", 32'(func_o), 32'(vecs[i].func));
      chk("vec rs1", rs1_data_o, vecs[i].rs1);
      chk("vec rs2", rs2_data_o, vecs[i].rs2);
      chk("vec imm", 32'(imm_o), 32'(vecs[i].imm));
      chk("vec rd", 32'(rd_addr_o), 32'(vecs[i].rd));
      chk("vec count", issue_count_o, 32'(i + 1));
      $display("vec %0d instr=%h func=%0d rs1=%h rs2=%h imm=%h rd=%0d count=%0d",
               i, instr_i, func_o, rs1_data_o, rs2_data_o, imm_o, rd_addr_o, issue_count_o);
      wb_write(vecs[i].rd, vecs[i].wbval);
    end

    // RAW stall: ADD r5,r1,r2 then SUB r6,r5,r1.
    instr_valid_i = 1'b1; instr_i = 16'h4A50;
    #1;
    chk("raw add ready", 32'(instr_ready_o), 32'd1);
    tick();
    instr_i = 16'h5D48;
    for (int k = 0; k < 3; k++) begin
      chk("raw stall ready", 32'(instr_ready_o), 32'd0);
      tick();
    end
    wb_en_i = 1'b1; wb_addr_i = 3'd5; wb_data_i = 32'hDEADBEEF;
    #1;
`ifdef DECODE_ISSUE_FORWARD_EN
    chk("raw fwd ready", 32'(instr_ready_o), 32'd1);
    tick();
    wb_en_i = 1'b0; instr_valid_i = 1'b0;
`else
    chk("raw wb-cycle ready", 32'(instr_ready_o), 32'd0);
    tick();
    wb_en_i = 1'b0;
    chk("raw post-wb ready", 32'(instr_ready_o), 32'd1);
    tick();
    instr_valid_i = 1'b0;
`endif
    chk("raw sub ex_valid", 32'(ex_valid_o), 32'd1);
    chk("raw sub rs1", rs1_data_o, 32'hDEADBEEF);
    chk("raw sub rs2", rs2_data_o, 32'h77777777);
    chk("raw sub rd", 32'(rd_addr_o), 32'd6);
    chk("raw count", issue_count_o, 32'd12);
    $display("raw: sub issued rs1=%h rs2=%h count=%0d", rs1_data_o, rs2_data_o, issue_count_o);
    wb_write(3'd6, 32'h12345678);

    // Back-pressure: slot held five cycles, then drain and refill with no bubble.
    ex_ready_i = 1'b0;
    instr_valid_i = 1'b1; instr_i = 16'h0650;
    #1;
    tick();
    instr_i = 16'h2E50;
    for (int k = 0; k < 5; k++) begin
      chk("bp ex_valid", 32'(ex_valid_o), 32'd1);
      chk("bp rs1", rs1_data_o, 32'h77777777);
      chk("bp rs2", rs2_data_o, 32'h88888888);
      chk("bp rd", 32'(rd_addr_o), 32'd3);
      chk("bp ready", 32'(instr_ready_o), 32'd0);
      tick();
    end
    ex_ready_i = 1'b1;
    #1;
    chk("bp release ready", 32'(instr_ready_o), 32'd1);
    tick();
    instr_valid_i = 1'b0;
    chk("b2b ex_valid", 32'(ex_valid_o), 32'd1);
    chk("b2b func", 32'(func_o), 32'd2);
    chk("b2b rd", 32'(rd_addr_o), 32'd7);
    chk("b2b count", issue_count_o, 32'd14);
    $display("backpressure: xor issued back-to-back rd=%0d count=%0d", rd_addr_o, issue_count_o);
    tick();
    chk("b2b drained", 32'(ex_valid_o), 32'd0);
    wb_write(3'd3, 32'h0);
    wb_write(3'd7, 32'h0);

    // Illegal opcode.
    instr_valid_i = 1'b1; instr_i = 16'hF000;
    #1;
    chk("ill ready", 32'(instr_ready_o), 32'd1);
    tick();
    instr_valid_i = 1'b0;
    chk("ill pulse", 32'(illegal_o), 32'd1);
    chk("ill ex_valid", 32'(ex_valid_o), 32'd0);
    chk("ill count", issue_count_o, 32'd14);
    tick();
    chk("ill pulse end", 32'(illegal_o), 32'd0);
    $display("illegal: opcode F consumed, count=%0d", issue_count_o);

    // Asynchronous reset during a stall with a full slot and a pending register.
    ex_ready_i = 1'b0;
    instr_valid_i = 1'b1; instr_i = 16'h4A50;
    #1;
    tick();
    instr_i = 16'h5D48;
    tick();
    #3;
    arst_i = 1'b1;
    #1;
    chk("arst ex_valid", 32'(ex_valid_o), 32'd0);
    chk("arst rs1", rs1_data_o, 32'd0);
    chk("arst rd", 32'(rd_addr_o), 32'd0);
    chk("arst count", issue_count_o, 32'd0);
    #2;
    arst_i = 1'b0; ex_ready_i = 1'b1;
    #1;
    chk("arst held ready", 32'(instr_ready_o), 32'd1);
    tick();
    instr_valid_i = 1'b0;
    chk("arst held ex_valid", 32'(ex_valid_o), 32'd1);
    chk("arst held func", 32'(func_o), 32'd5);
    chk("arst held rs1", rs1_data_o, 32'd0);
    chk("arst held rs2", rs2_data_o, 32'd0);
    chk("arst held rd", 32'(rd_addr_o), 32'd6);
    chk("arst held count", issue_count_o, 32'd1);
    $display("reset mid-stall: held sub issued rs1=%h count=%0d", rs1_data_o, issue_count_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
